// File: rtl/hex_scroll_display.sv
// hex_scroll_display: scrolling seven-segment message engine.
// A small character buffer is rendered into a window of NUM_DIGITS active-low
// digits. The window start (pos) advances every scroll_ms milliseconds, either
// wrapping around the message or running once and then blanking the display.
module hex_scroll_display #(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_DEPTH  = 16,
    parameter int CLK_DIV    = 50000,
    parameter int AW         = $clog2(MSG_DEPTH)
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [4:0]              wr_data,
    input  logic [AW:0]             msg_len,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    mode,
    input  logic [9:0]              scroll_ms,
    output logic [8*NUM_DIGITS-1:0] hex_out,
    output logic                    busy,
    output logic                    done
);

    // Prescaler width; a divide-by-one still needs a one-bit counter.
    localparam int             PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [AW:0]    DEPTH_LEN = (AW + 1)'(MSG_DEPTH);
    localparam logic [4:0]     CODE_BLANK = 5'h10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Character code to active-low segment pattern; DP (bit 7) is always off.
    function automatic logic [7:0] seg_decode(input logic [4:0] code);
        logic [7:0] seg;
        case (code)
            5'h00:   seg = 8'hC0;
            5'h01:   seg = 8'hF9;
            5'h02:   seg = 8'hA4;
            5'h03:   seg = 8'hB0;
            5'h04:   seg = 8'h99;
            5'h05:   seg = 8'h92;
            5'h06:   seg = 8'h82;
            5'h07:   seg = 8'hF8;
            5'h08:   seg = 8'h80;
            5'h09:   seg = 8'h90;
            5'h0A:   seg = 8'h88;
            5'h0B:   seg = 8'h83;
            5'h0C:   seg = 8'hC6;
            5'h0D:   seg = 8'hA1;
            5'h0E:   seg = 8'h86;
            5'h0F:   seg = 8'h8E;
            5'h11:   seg = 8'hBF;
            5'h12:   seg = 8'h89;
            5'h13:   seg = 8'hC7;
            5'h14:   seg = 8'h8C;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    state_t                  state_q, state_d;
    logic [AW-1:0]           pos_q, pos_d;
    logic [AW:0]             len_q, len_d;
    logic                    mode_q, mode_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [9:0]              step_q, step_d;
    logic [4:0]              buf_q [MSG_DEPTH];
    logic [4:0]              buf_d [MSG_DEPTH];
    logic [8*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [AW:0]             len_clamp_s;
    logic                    tick_s;
    logic                    last_pos_s;
    logic [10:0]             step_inc_s;

    // Helper terms: clamped length, millisecond tick, end-of-message and step+1.
    always_comb begin
        if (msg_len > DEPTH_LEN) begin
            len_clamp_s = DEPTH_LEN;
        end else begin
            len_clamp_s = msg_len;
        end
        tick_s     = (presc_q == PRESC_MAX);
        last_pos_s = ({1'b0, pos_q} == (len_q - (AW + 1)'(1)));
        step_inc_s = {1'b0, step_q} + 11'd1;
    end

    // Sequencer: start/restart, pause freeze, prescaler, step counter and pos advance.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        len_d   = len_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        step_d  = step_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (len_clamp_s != {(AW + 1){1'b0}})) begin
                    state_d = ST_RUN;
                    pos_d   = {AW{1'b0}};
                    len_d   = len_clamp_s;
                    mode_d  = mode;
                    presc_d = {PW{1'b0}};
                    step_d  = 10'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_PAUSE: begin
                if (start) begin
                    // A restart with an empty message stops the engine instead.
                    if (len_clamp_s != {(AW + 1){1'b0}}) begin
                        state_d = ST_RUN;
                        len_d   = len_clamp_s;
                        mode_d  = mode;
                    end else begin
                        state_d = ST_IDLE;
                    end
                    pos_d   = {AW{1'b0}};
                    presc_d = {PW{1'b0}};
                    step_d  = 10'd0;
                end else if (pause) begin
                    // Counters hold from the very cycle pause is seen, so run time is preserved.
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                    if (tick_s) begin
                        presc_d = {PW{1'b0}};
                        if (scroll_ms == 10'd0) begin
                            step_d = 10'd0;
                        end else if (step_inc_s >= {1'b0, scroll_ms}) begin
                            step_d = 10'd0;
                            if (last_pos_s) begin
                                pos_d = {AW{1'b0}};
                                if (mode_q) begin
                                    state_d = ST_IDLE;
                                    done_d  = 1'b1;
                                end else begin
                                    state_d = ST_RUN;
                                end
                            end else begin
                                pos_d = pos_q + AW'(1);
                            end
                        end else begin
                            step_d = step_inc_s[9:0];
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pos_d   = {AW{1'b0}};
                presc_d = {PW{1'b0}};
                step_d  = 10'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Character buffer write port; writes are accepted in every state.
    always_comb begin
        buf_d = buf_q;
        if (wr_en) begin
            buf_d[wr_addr] = wr_data;
        end else begin
            buf_d[wr_addr] = buf_q[wr_addr];
        end
    end

    // Window render from the current pos and live buffer contents, leftmost digit first.
    always_comb begin
        logic [AW:0]   wrap_idx_s;
        logic [AW+1:0] raw_idx_s;
        logic [4:0]    code_s;
        hex_d      = {(8 * NUM_DIGITS){1'b1}};
        wrap_idx_s = {1'b0, pos_q};
        raw_idx_s  = {(AW + 2){1'b0}};
        code_s     = CODE_BLANK;
        if (state_q != ST_IDLE) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                raw_idx_s = {2'b00, pos_q} + (AW + 2)'(i);
                if (mode_q) begin
                    // One-shot: positions past the message end are blank.
                    if (raw_idx_s >= {1'b0, len_q}) begin
                        code_s = CODE_BLANK;
                    end else begin
                        code_s = buf_q[raw_idx_s[AW-1:0]];
                    end
                end else begin
                    code_s = buf_q[wrap_idx_s[AW-1:0]];
                end
                hex_d[8*(NUM_DIGITS-1-i) +: 8] = seg_decode(code_s);
                // Running modulo-len index, so lengths shorter than the window repeat.
                if ((wrap_idx_s + (AW + 1)'(1)) >= len_q) begin
                    wrap_idx_s = {(AW + 1){1'b0}};
                end else begin
                    wrap_idx_s = wrap_idx_s + (AW + 1)'(1);
                end
            end
        end else begin
            hex_d = {(8 * NUM_DIGITS){1'b1}};
        end
    end

    // State, buffer and output registers with synchronous reset.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= ST_IDLE;
            pos_q   <= {AW{1'b0}};
            len_q   <= {(AW + 1){1'b0}};
            mode_q  <= 1'b0;
            presc_q <= {PW{1'b0}};
            step_q  <= 10'd0;
            hex_q   <= {(8 * NUM_DIGITS){1'b1}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < MSG_DEPTH; i++) begin
                buf_q[i] <= CODE_BLANK;
            end
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            hex_q   <= hex_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            buf_q   <= buf_d;
        end
    end

    assign hex_out = hex_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
